// File: rtl/rxuart_pkg.sv
// Shared UART receive definitions: RX state encodings, default baud divisor, frame width.
package rxuart_pkg;

    localparam logic [23:0] UART_DEFAULT_CPB = 24'd68;
    localparam int          UART_DATA_BITS   = 8;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_WAIT_HI = 3'd4
    } rx_state_t;

endpackage

// File: rtl/rxuart_sync2.sv
// sync2: two-flop synchroniser for an asynchronous single-bit input, with a
// parameterised reset value so idle-high and idle-low lines both come up quiet.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/rxuart.sv
// rxuart: 8N1 UART receiver with stop-bit error strobe.
// Define RXUART_MAJORITY_EN to take each bit as a 2-of-3 vote around the sample tick.
module rxuart
    import rxuart_pkg::*;
#(
    parameter logic [23:0] CLOCKS_PER_BAUD = UART_DEFAULT_CPB
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_uart_rx,
    output logic       o_wr,
    output logic [7:0] o_data,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam logic [23:0] HALF_LOAD = (CLOCKS_PER_BAUD >> 1) - 24'd1;
    localparam logic [23:0] FULL_LOAD = CLOCKS_PER_BAUD - 24'd1;
    localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

    rx_state_t                 r_state;
    rx_state_t                 w_state_nxt;
    logic [23:0]               r_baud_cnt;
    logic [2:0]                r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      w_rx_s;
    logic                      w_tick;
    logic                      w_sample;

    sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_async(i_uart_rx),
        .o_sync (w_rx_s)
    );

`ifdef RXUART_MAJORITY_EN
    // Vote window is the two previous rx_s values plus the live one at the tick.
    logic [1:0] r_hist;
    logic [2:0] w_win;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_hist <= 2'b11;
        else          r_hist <= {r_hist[0], w_rx_s};
    end

    assign w_win    = {r_hist, w_rx_s};
    assign w_sample = (w_win[0] & w_win[1]) | (w_win[0] & w_win[2]) | (w_win[1] & w_win[2]);
`else
    assign w_sample = w_rx_s;
`endif

    assign w_tick = (r_baud_cnt == 24'd0);
    assign o_busy = (r_state != RX_IDLE);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= RX_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RX_IDLE:    if (!w_rx_s) w_state_nxt = RX_START;
            RX_START:   if (w_tick) w_state_nxt = w_sample ? RX_IDLE : RX_DATA;
            RX_DATA:    if (w_tick && (r_bit_cnt == LAST_BIT)) w_state_nxt = RX_STOP;
            RX_STOP:    if (w_tick) w_state_nxt = w_sample ? RX_IDLE : RX_WAIT_HI;
            RX_WAIT_HI: if (w_rx_s) w_state_nxt = RX_IDLE;
            default:    w_state_nxt = RX_IDLE;
        endcase
    end

    // Leaving STOP straight to IDLE frees the FSM half a bit early for back-to-back frames.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_baud_cnt  <= 24'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= '0;
            o_wr        <= 1'b0;
            o_data      <= 8'h00;
            o_frame_err <= 1'b0;
        end else begin
            o_wr        <= 1'b0;
            o_frame_err <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_bit_cnt <= 3'd0;
                    if (!w_rx_s) r_baud_cnt <= HALF_LOAD;
                end
                RX_START, RX_DATA, RX_STOP: begin
                    r_baud_cnt <= w_tick ? FULL_LOAD : r_baud_cnt - 24'd1;
                    if (w_tick && (r_state == RX_DATA)) begin
                        r_shift   <= {w_sample, r_shift[UART_DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    if (w_tick && (r_state == RX_STOP)) begin
                        if (w_sample) begin
                            o_wr   <= 1'b1;
                            o_data <= r_shift;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rxuart.sv
// Scoreboard bench for rxuart: expected bytes/frame errors queued at send, checked on strobe.
module tb_rxuart;

    localparam int CPB = 68;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       i_clk;
    logic       i_reset;
    logic       i_uart_rx;
    logic       o_wr;
    logic [7:0] o_data;
    logic       o_frame_err;
    logic       o_busy;

    int   n_checks;
    int   n_errors;
    int   cyc;
    int   start_cyc;
    int   last_wr_cyc;
    int   n_wr;
    int   n_ferr;
    logic prev_strobe;
    logic [7:0] last_good;
    exp_t exp_q[$];

    rxuart #(
        .CLOCKS_PER_BAUD(24'd68)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_uart_rx  (i_uart_rx),
        .o_wr       (o_wr),
        .o_data     (o_data),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Strobe monitor: pops one expectation per o_wr / o_frame_err pulse.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_reset) begin
            prev_strobe = 1'b0;
        end else begin
            if (o_wr || o_frame_err) begin
                check_eq("strobe_gap", prev_strobe, 1'b0);
                check_eq("strobe_excl", o_wr & o_frame_err, 1'b0);
                check_eq("strobe_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("strobe_kind", o_frame_err, e.is_err);
                    check_eq("strobe_data", o_data, e.data);
                end
                if (o_wr) begin
                    n_wr++;
                    last_wr_cyc = cyc;
                end
                if (o_frame_err) n_ferr++;
            end
            prev_strobe = o_wr | o_frame_err;
        end
    end

    task automatic drive_bit(input logic b, input bit glitch);
        i_uart_rx = b;
        if (glitch) begin
            repeat (CPB / 2) @(posedge i_clk);
            #1 i_uart_rx = ~b;
            @(posedge i_clk);
            #1 i_uart_rx = b;
            repeat (CPB - CPB / 2 - 1) @(posedge i_clk);
            #1;
        end else begin
            repeat (CPB) @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input int glitch_bit);
        start_cyc = cyc;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i], i == glitch_bit);
        drive_bit(1'b1, 1'b0);
    endtask

    task automatic push_good(input logic [7:0] data);
        exp_q.push_back('{is_err: 1'b0, data: data});
        last_good = data;
    endtask

    initial begin
        int w0;
        int f0;
        logic [7:0] t6_exp;
        n_checks    = 0;
        n_errors    = 0;
        n_wr        = 0;
        n_ferr      = 0;
        last_wr_cyc = 0;
        prev_strobe = 1'b0;
        last_good   = 8'h00;
        i_reset     = 1'b0;
        i_uart_rx   = 1'b1;
        #1;
        check_eq("reset_wr", o_wr, 1'b0);
        check_eq("reset_data", o_data, 8'h00);
        check_eq("reset_ferr", o_frame_err, 1'b0);
        check_eq("reset_busy", o_busy, 1'b0);
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;

        // Single frame with exact strobe latency
        push_good(8'h55);
        send_frame(8'h55, -1);
        check_eq("t1_latency", last_wr_cyc - start_cyc, 32'd649);
        check_eq("t1_busy_after", o_busy, 1'b0);
        check_eq("t1_data", o_data, 8'h55);

        // Back-to-back frames with no idle gap
        w0 = n_wr;
        push_good(8'h00);
        send_frame(8'h00, -1);
        push_good(8'hFF);
        send_frame(8'hFF, -1);
        check_eq("t2_count", n_wr - w0, 32'd2);
        check_eq("t2_data", o_data, 8'hFF);

        // Short low glitch must be rejected
        w0 = n_wr;
        f0 = n_ferr;
        i_uart_rx = 1'b0;
        repeat (10) @(posedge i_clk);
        #1 check_eq("t3_busy_during", o_busy, 1'b1);
        repeat (10) @(posedge i_clk);
        #1 i_uart_rx = 1'b1;
        repeat (30) @(posedge i_clk);
        #1;
        check_eq("t3_busy_after", o_busy, 1'b0);
        check_eq("t3_no_strobe", (n_wr - w0) + (n_ferr - f0), 32'd0);

        // Stop bit low, line held low 3 bauds
        w0 = n_wr;
        f0 = n_ferr;
        exp_q.push_back('{is_err: 1'b1, data: last_good});
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(8'hA5 >> i, 1'b0);
        i_uart_rx = 1'b0;
        repeat (3 * CPB) @(posedge i_clk);
        #1;
        check_eq("t4_busy_low_line", o_busy, 1'b1);
        check_eq("t4_ferr_count", n_ferr - f0, 32'd1);
        check_eq("t4_no_wr", n_wr - w0, 32'd0);
        i_uart_rx = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        check_eq("t4_busy_released", o_busy, 1'b0);
        check_eq("t4_data_kept", o_data, last_good);

        // Reset mid-frame, then a clean frame
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(8'h3C >> i, 1'b0);
        i_reset = 1'b0;
        #2;
        check_eq("t5_rst_wr", o_wr, 1'b0);
        check_eq("t5_rst_data", o_data, 8'h00);
        check_eq("t5_rst_ferr", o_frame_err, 1'b0);
        check_eq("t5_rst_busy", o_busy, 1'b0);
        repeat (3) @(posedge i_clk);
        #1 i_uart_rx = 1'b1;
        check_eq("t5_rst_busy_hold", o_busy, 1'b0);
        i_reset   = 1'b1;
        last_good = 8'h00;
        repeat (10) @(posedge i_clk);
        #1;
        w0 = n_wr;
        push_good(8'hC3);
        send_frame(8'hC3, -1);
        check_eq("t5_count", n_wr - w0, 32'd1);
        check_eq("t5_data", o_data, 8'hC3);

        // One-cycle inverted glitch at the bit-2 sample tick
`ifdef RXUART_MAJORITY_EN
        t6_exp = 8'h00;
`else
        t6_exp = 8'h04;
`endif
        push_good(t6_exp);
        send_frame(8'h00, 2);
        check_eq("t6_data", o_data, t6_exp);

        repeat (20) @(posedge i_clk);
        #1;
        check_eq("queue_drained", exp_q.size(), 32'd0);
        check_eq("total_wr", n_wr, 32'd5);
        check_eq("total_ferr", n_ferr, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        repeat (30000) @(posedge i_clk);
        $display("FAIL watchdog: observed cycle budget exhausted, expected completion");
        $fatal(1, "timeout");
    end

endmodule
